d_format_decoder: RTL and testbench

Single-cycle registered decoder for Power ISA D-form instructions, one of the format-specific decoders behind the decode-stage format classifier. It validates the 6-bit primary opcode against the D-form set and emits a normalized micro-op header (opcode, functional unit, operand access flags, immediate handling) plus the raw 26-bit operand body to the backend.

---
 rtl/d_format_decoder_pkg.sv | 65 ++++++
 rtl/d_format_opcode_lut.sv | 80 ++++++++
 rtl/d_format_decoder.sv | 127 ++++++++++++
 tb/tb_d_format_decoder.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/d_format_decoder_pkg.sv
// Shared constants and types for the Power ISA D-form decoder.
// Holds unit IDs, register access codes, the D format code, opcode values
// and the decoded-header bundle passed from the opcode table to the top.
package d_format_decoder_pkg;

   localparam int ADDR_W    = 64;
   localparam int INSTR_W   = 32;
   localparam int PID_W     = 20;
   localparam int TID_W     = 16;
   localparam int MAJ_ID_W  = 64;
   localparam int MIN_ID_W  = 7;
   localparam int OPCODE_W  = 12;
   localparam int PRIM_W    = 6;
   localparam int REG_W     = 5;
   localparam int IMM_W     = 16;
   localparam int FMT_W     = 25;
   localparam int BODY_W    = 26;

   localparam logic [1:0] REG_NONE  = 2'b00;
   localparam logic [1:0] REG_READ  = 2'b10;
   localparam logic [1:0] REG_WRITE = 2'b01;
   localparam logic [1:0] REG_RW    = 2'b11;

   localparam logic [2:0] FX_UNIT     = 3'd0;
   localparam logic [2:0] FP_UNIT     = 3'd1;
   localparam logic [2:0] VX_UNIT     = 3'd2;
   localparam logic [2:0] CR_UNIT     = 3'd3;
   localparam logic [2:0] LS_UNIT     = 3'd4;
   localparam logic [2:0] BRANCH_UNIT = 3'd6;

   localparam logic [FMT_W-1:0] D_FORMAT = 25'd32;

   localparam logic [5:0] OP_TDI      = 6'd2;
   localparam logic [5:0] OP_TWI      = 6'd3;
   localparam logic [5:0] OP_MULLI    = 6'd7;
   localparam logic [5:0] OP_SUBFIC   = 6'd8;
   localparam logic [5:0] OP_CMPLI    = 6'd10;
   localparam logic [5:0] OP_CMPI     = 6'd11;
   localparam logic [5:0] OP_ADDIC    = 6'd12;
   localparam logic [5:0] OP_ADDIC_RC = 6'd13;
   localparam logic [5:0] OP_ADDI     = 6'd14;
   localparam logic [5:0] OP_ADDIS    = 6'd15;
   localparam logic [5:0] OP_ORI      = 6'd24;
   localparam logic [5:0] OP_ORIS     = 6'd25;
   localparam logic [5:0] OP_XORI     = 6'd26;
   localparam logic [5:0] OP_XORIS    = 6'd27;
   localparam logic [5:0] OP_ANDI_RC  = 6'd28;
   localparam logic [5:0] OP_ANDIS_RC = 6'd29;
   localparam logic [5:0] OP_LMW      = 6'd46;
   localparam logic [5:0] OP_STMW     = 6'd47;

   typedef struct packed {
      logic       valid;
      logic [2:0] unit;
      logic [1:0] op1_rw;
      logic [1:0] op2_rw;
      logic       op1_is_reg;
      logic       op2_is_reg;
      logic       imm_ext;
      logic       imm_shift;
      logic       mod_cr;
      logic [6:0] num_uops;
   } dec_info_t;

endpackage

// File: rtl/d_format_opcode_lut.sv
// Combinational D-form opcode table: opcode/RT/RA -> valid, unit, flags.
// Ports: opcode_i, op1_i (bits 6:10), ra_i -> info_o. FP rows need DFORMAT_FP_EN.
module d_format_opcode_lut
   import d_format_decoder_pkg::*;
(
   input  logic [5:0] opcode_i,
   input  logic [4:0] op1_i,
   input  logic [4:0] ra_i,
   output dec_info_t  info_o
);

   logic is_trap;
   logic is_cmp;
   logic is_arith;
   logic is_logic;
   logic is_int_ls;
   logic is_fp_ls;
   logic is_ls;
   logic is_store;
   logic is_update;
   logic is_multi;
   logic ra_zero_form;

   always_comb begin
      is_trap   = (opcode_i == OP_TDI) || (opcode_i == OP_TWI);
      is_cmp    = (opcode_i == OP_CMPLI) || (opcode_i == OP_CMPI);
      is_arith  = (opcode_i == OP_MULLI) || (opcode_i == OP_SUBFIC) ||
                  (opcode_i[5:2] == 4'b0011);
      is_logic  = (opcode_i >= OP_ORI) && (opcode_i <= OP_ANDIS_RC);
      // 32..47 are the integer loads/stores including lmw/stmw
      is_int_ls = (opcode_i[5:4] == 2'b10);
`ifdef DFORMAT_FP_EN
      is_fp_ls  = (opcode_i[5:3] == 3'b110);
`else
      is_fp_ls  = 1'b0;
`endif
      is_ls     = is_int_ls || is_fp_ls;
      // stores: 36-39, 44-45, 47 (stmw), 52-55 (FP)
      is_store  = (opcode_i[5:2] == 4'b1001) ||
                  (opcode_i[5:1] == 5'b10110) ||
                  (opcode_i == OP_STMW) ||
                  (is_fp_ls && opcode_i[2]);
      is_update = is_ls && opcode_i[0];
      is_multi  = (opcode_i == OP_LMW) || (opcode_i == OP_STMW);
      // RA==0 means literal zero for these forms, not GPR0
      ra_zero_form = (opcode_i == OP_ADDI) || (opcode_i == OP_ADDIS) ||
                     (is_ls && !opcode_i[0]);

      info_o = '0;
      info_o.valid = is_trap || is_cmp || is_arith || is_logic || is_ls;

      unique case (1'b1)
         is_trap: info_o.unit = BRANCH_UNIT;
         is_ls:   info_o.unit = LS_UNIT;
         default: info_o.unit = FX_UNIT;
      endcase

      unique case (1'b1)
         is_trap || is_cmp: info_o.op1_rw = REG_NONE;
         is_store:          info_o.op1_rw = REG_READ;
         default:           info_o.op1_rw = REG_WRITE;
      endcase

      info_o.op1_is_reg = !(is_trap || is_cmp);
      info_o.op2_rw     = is_update ? REG_RW : REG_READ;
      info_o.op2_is_reg = !(ra_zero_form && (ra_i == 5'd0));
      info_o.imm_ext    = !(is_logic || (opcode_i == OP_CMPLI));
      info_o.imm_shift  = (opcode_i == OP_ADDIS) ||
                          (opcode_i == OP_ORIS) ||
                          (opcode_i == OP_XORIS) ||
                          (opcode_i == OP_ANDIS_RC);
      info_o.mod_cr     = is_cmp ||
                          (opcode_i == OP_ADDIC_RC) ||
                          (opcode_i == OP_ANDI_RC) ||
                          (opcode_i == OP_ANDIS_RC);
      // lmw/stmw move RT..r31
      info_o.num_uops   = is_multi ? (7'd32 - {2'b00, op1_i}) : 7'd1;
   end

endmodule

// File: rtl/d_format_decoder.sv
// Registered Power ISA D-form decoder: validates opcode, emits micro-op header.
// Ports: clock/reset/enable/stall, format+opcode+instruction+metadata in;
// enable_o, opcode/unit/operand flags/body and metadata copies out.
// Optional FP load/store decoding (opcodes 48-55) with DFORMAT_FP_EN.
module d_format_decoder
   import d_format_decoder_pkg::*;
(
   input  logic                clock_i,
   input  logic                reset_i,
   input  logic                enable_i,
   input  logic                stall_i,
   input  logic [FMT_W-1:0]    instFormat_i,
   input  logic [PRIM_W-1:0]   instructionOpcode_i,
   input  logic [INSTR_W-1:0]  instruction_i,
   input  logic [ADDR_W-1:0]   instructionAddress_i,
   input  logic                is64Bit_i,
   input  logic [PID_W-1:0]    instructionPid_i,
   input  logic [TID_W-1:0]    instructionTid_i,
   input  logic [MAJ_ID_W-1:0] instructionMajId_i,
   output logic                enable_o,
   output logic [OPCODE_W-1:0] opcode_o,
   output logic [ADDR_W-1:0]   instructionAddress_o,
   output logic                is64Bit_o,
   output logic [PID_W-1:0]    instPid_o,
   output logic [TID_W-1:0]    instTid_o,
   output logic [MAJ_ID_W-1:0] instMajId_o,
   output logic [2:0]          functionalUnitType_o,
   output logic [MIN_ID_W-1:0] instMinId_o,
   output logic [MIN_ID_W-1:0] numMicroOps_o,
   output logic [1:0]          op1rw_o,
   output logic [1:0]          op2rw_o,
   output logic                op1isReg_o,
   output logic                op2isReg_o,
   output logic                immIsExtended_o,
   output logic                immIsShifted_o,
   output logic                modifiesCR_o,
   output logic [BODY_W-1:0]   instructionBody_o
);

   dec_info_t           lut_info;
   dec_info_t           info_d, info_q;
   logic [PRIM_W-1:0]   prim_d, prim_q;
   logic [BODY_W-1:0]   body_d, body_q;
   logic [ADDR_W-1:0]   addr_d, addr_q;
   logic                is64_d, is64_q;
   logic [PID_W-1:0]    pid_d, pid_q;
   logic [TID_W-1:0]    tid_d, tid_q;
   logic [MAJ_ID_W-1:0] maj_d, maj_q;
   logic                unused_opcode_bits;

   // primary opcode arrives separately from the classifier
   assign unused_opcode_bits = ^instruction_i[31:26];

   d_format_opcode_lut u_lut (
      .opcode_i (instructionOpcode_i),
      .op1_i    (instruction_i[25:21]),
      .ra_i     (instruction_i[20:16]),
      .info_o   (lut_info)
   );

   always_comb begin
      info_d = info_q;
      prim_d = prim_q;
      body_d = body_q;
      addr_d = addr_q;
      is64_d = is64_q;
      pid_d  = pid_q;
      tid_d  = tid_q;
      maj_d  = maj_q;
      if (!stall_i) begin
         info_d.valid = 1'b0;
         if (enable_i) begin
            info_d       = lut_info;
            info_d.valid = lut_info.valid && (instFormat_i == D_FORMAT);
            prim_d       = instructionOpcode_i;
            body_d       = instruction_i[25:0];
            addr_d       = instructionAddress_i;
            is64_d       = is64Bit_i;
            pid_d        = instructionPid_i;
            tid_d        = instructionTid_i;
            maj_d        = instructionMajId_i;
         end
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         info_q <= '0;
         prim_q <= '0;
         body_q <= '0;
         addr_q <= '0;
         is64_q <= 1'b0;
         pid_q  <= '0;
         tid_q  <= '0;
         maj_q  <= '0;
      end else begin
         info_q <= info_d;
         prim_q <= prim_d;
         body_q <= body_d;
         addr_q <= addr_d;
         is64_q <= is64_d;
         pid_q  <= pid_d;
         tid_q  <= tid_d;
         maj_q  <= maj_d;
      end
   end

   assign enable_o             = info_q.valid;
   assign opcode_o             = {prim_q, 6'b000000};
   assign instructionAddress_o = addr_q;
   assign is64Bit_o            = is64_q;
   assign instPid_o            = pid_q;
   assign instTid_o            = tid_q;
   assign instMajId_o          = maj_q;
   assign functionalUnitType_o = info_q.unit;
   assign instMinId_o          = '0;
   assign numMicroOps_o        = info_q.num_uops;
   assign op1rw_o              = info_q.op1_rw;
   assign op2rw_o              = info_q.op2_rw;
   assign op1isReg_o           = info_q.op1_is_reg;
   assign op2isReg_o           = info_q.op2_is_reg;
   assign immIsExtended_o      = info_q.imm_ext;
   assign immIsShifted_o       = info_q.imm_shift;
   assign modifiesCR_o         = info_q.mod_cr;
   assign instructionBody_o    = body_q;

endmodule

// File: tb/tb_d_format_decoder.sv
// Self-checking bench for d_format_decoder with a behavioural reference.
// Directed cases, opcode sweep, stall/reset behaviour and random traffic.
module tb_d_format_decoder;

`ifdef DFORMAT_FP_EN
   localparam bit FP_ON = 1'b1;
`else
   localparam bit FP_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_i;
   logic        enable_i;
   logic        stall_i;
   logic [24:0] instFormat_i;
   logic [5:0]  instructionOpcode_i;
   logic [31:0] instruction_i;
   logic [63:0] instructionAddress_i;
   logic        is64Bit_i;
   logic [19:0] instructionPid_i;
   logic [15:0] instructionTid_i;
   logic [63:0] instructionMajId_i;
   logic        enable_o;
   logic [11:0] opcode_o;
   logic [63:0] instructionAddress_o;
   logic        is64Bit_o;
   logic [19:0] instPid_o;
   logic [15:0] instTid_o;
   logic [63:0] instMajId_o;
   logic [2:0]  functionalUnitType_o;
   logic [6:0]  instMinId_o;
   logic [6:0]  numMicroOps_o;
   logic [1:0]  op1rw_o;
   logic [1:0]  op2rw_o;
   logic        op1isReg_o;
   logic        op2isReg_o;
   logic        immIsExtended_o;
   logic        immIsShifted_o;
   logic        modifiesCR_o;
   logic [25:0] instructionBody_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   d_format_decoder dut (
      .clock_i              (clk),
      .reset_i              (reset_i),
      .enable_i             (enable_i),
      .stall_i              (stall_i),
      .instFormat_i         (instFormat_i),
      .instructionOpcode_i  (instructionOpcode_i),
      .instruction_i        (instruction_i),
      .instructionAddress_i (instructionAddress_i),
      .is64Bit_i            (is64Bit_i),
      .instructionPid_i     (instructionPid_i),
      .instructionTid_i     (instructionTid_i),
      .instructionMajId_i   (instructionMajId_i),
      .enable_o             (enable_o),
      .opcode_o             (opcode_o),
      .instructionAddress_o (instructionAddress_o),
      .is64Bit_o            (is64Bit_o),
      .instPid_o            (instPid_o),
      .instTid_o            (instTid_o),
      .instMajId_o          (instMajId_o),
      .functionalUnitType_o (functionalUnitType_o),
      .instMinId_o          (instMinId_o),
      .numMicroOps_o        (numMicroOps_o),
      .op1rw_o              (op1rw_o),
      .op2rw_o              (op2rw_o),
      .op1isReg_o           (op1isReg_o),
      .op2isReg_o           (op2isReg_o),
      .immIsExtended_o      (immIsExtended_o),
      .immIsShifted_o       (immIsShifted_o),
      .modifiesCR_o         (modifiesCR_o),
      .instructionBody_o    (instructionBody_o)
   );

   // ---------------- reference model ----------------
   function automatic bit ref_ok(input int op);
      if (op inside {2, 3, 7, 8, 10, 11, [12:15], [24:29], [32:47]})
         return 1'b1;
      if (FP_ON && (op inside {[48:55]}))
         return 1'b1;
      return 1'b0;
   endfunction

   // {opcode12, unit3, op1rw2, op2rw2, op1reg, op2reg, ext, shift, cr,
   //  num7, minid7, body26}
   function automatic logic [63:0] ref_hdr(input logic [31:0] ins);
      int op;
      int rt;
      int ra;
      logic [2:0] unit;
      logic [1:0] rw1;
      logic [1:0] rw2;
      bit r1, r2, ext, sh, cr;
      int num;
      op = int'(ins[31:26]);
      rt = int'(ins[25:21]);
      ra = int'(ins[20:16]);
      if (op inside {2, 3}) unit = 3'd6;
      else if (op >= 32) unit = 3'd4;
      else unit = 3'd0;
      if (op inside {2, 3, 10, 11}) rw1 = 2'b00;
      else if (op inside {[36:39], 44, 45, 47, [52:55]}) rw1 = 2'b10;
      else rw1 = 2'b01;
      rw2 = (op >= 33 && op <= 55 && (op % 2) == 1) ? 2'b11 : 2'b10;
      r1  = !(op inside {2, 3, 10, 11});
      r2  = !(ra == 0 && (op == 14 || op == 15 ||
                          (op >= 32 && op <= 55 && (op % 2) == 0)));
      ext = !(op inside {[24:29], 10});
      sh  = op inside {15, 25, 27, 29};
      cr  = op inside {10, 11, 13, 28, 29};
      num = (op == 46 || op == 47) ? 32 - rt : 1;
      return {ins[31:26], 6'd0, unit, rw1, rw2, r1, r2, ext, sh, cr,
              7'(num), 7'd0, ins[25:0]};
   endfunction

   function automatic logic [31:0] mk(input int op, input int rt,
                                      input int ra, input int imm);
      return {6'(op), 5'(rt), 5'(ra), 16'(imm)};
   endfunction

   function automatic logic [63:0] dut_hdr();
      return {opcode_o, functionalUnitType_o, op1rw_o, op2rw_o,
              op1isReg_o, op2isReg_o, immIsExtended_o, immIsShifted_o,
              modifiesCR_o, numMicroOps_o, instMinId_o, instructionBody_o};
   endfunction

   function automatic logic [164:0] dut_pt();
      return {instructionAddress_o, is64Bit_o, instPid_o, instTid_o,
              instMajId_o};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit en, input int fmt, input logic [31:0] ins);
      enable_i             = en;
      instFormat_i         = 25'(fmt);
      instruction_i        = ins;
      instructionOpcode_i  = ins[31:26];
      instructionAddress_i = {$urandom, $urandom};
      is64Bit_i            = 1'($urandom);
      instructionPid_i     = 20'($urandom);
      instructionTid_i     = 16'($urandom);
      instructionMajId_i   = {$urandom, $urandom};
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset_i = 1'b1;
      stall_i = 1'b0;
      drive(1'b0, 32, 32'h0);
      #2;
      n_checks++;
      if ({enable_o, dut_hdr(), dut_pt()} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h want 0",
                  {enable_o, dut_hdr(), dut_pt()});
      end
      step();
      reset_i = 1'b0;
      step();
   endtask

   task automatic test_addis();
      logic [31:0] ins;
      ins = 32'h3C601234;
      drive(1'b1, 32, ins);
      step();
      n_checks++;
      if (enable_o !== 1'b1) begin
         n_fail++; $display("FAIL addis_en: got %b want 1", enable_o);
      end
      n_checks++;
      if (functionalUnitType_o !== 3'd0) begin
         n_fail++;
         $display("FAIL addis_unit: got %0d want 0", functionalUnitType_o);
      end
      n_checks++;
      if ({op1rw_o, op2isReg_o, immIsShifted_o, immIsExtended_o}
          !== 5'b01011) begin
         n_fail++;
         $display("FAIL addis_flags: got %b want 01011",
                  {op1rw_o, op2isReg_o, immIsShifted_o, immIsExtended_o});
      end
      n_checks++;
      if (instructionBody_o !== 26'h0601234) begin
         n_fail++;
         $display("FAIL addis_body: got %h want 0601234", instructionBody_o);
      end
      n_checks++;
      if (opcode_o !== 12'h3C0) begin
         n_fail++; $display("FAIL addis_opcode: got %h want 3c0", opcode_o);
      end
   endtask

   task automatic test_loads();
      drive(1'b1, 32, 32'h84A40008);
      step();
      n_checks++;
      if ({enable_o, functionalUnitType_o, op2rw_o, numMicroOps_o}
          !== {1'b1, 3'd4, 2'b11, 7'd1}) begin
         n_fail++;
         $display("FAIL lwzu: got en=%b unit=%0d op2rw=%b num=%0d want 1 4 11 1",
                  enable_o, functionalUnitType_o, op2rw_o, numMicroOps_o);
      end
      drive(1'b1, 32, mk(46, 29, 1, 0));
      step();
      n_checks++;
      if (numMicroOps_o !== 7'd3 || enable_o !== 1'b1) begin
         n_fail++;
         $display("FAIL lmw_num: got %0d en=%b want 3 en=1",
                  numMicroOps_o, enable_o);
      end
      drive(1'b1, 32, mk(47, 0, 1, 0));
      step();
      n_checks++;
      if (numMicroOps_o !== 7'd32 || op1rw_o !== 2'b10) begin
         n_fail++;
         $display("FAIL stmw_r0: got num=%0d op1rw=%b want 32 10",
                  numMicroOps_o, op1rw_o);
      end
   endtask

   task automatic test_andi_and_format();
      drive(1'b1, 32, mk(28, 2, 1, 16'hFFFF));
      step();
      n_checks++;
      if ({enable_o, modifiesCR_o, immIsExtended_o} !== 3'b110) begin
         n_fail++;
         $display("FAIL andi_flags: got %b want 110",
                  {enable_o, modifiesCR_o, immIsExtended_o});
      end
      drive(1'b1, 16, mk(14, 3, 4, 5));
      step();
      n_checks++;
      if (enable_o !== 1'b0) begin
         n_fail++; $display("FAIL wrong_format: got %b want 0", enable_o);
      end
   endtask

   task automatic test_sweep();
      int cnt;
      int want;
      cnt  = 0;
      want = FP_ON ? 40 : 32;
      for (int op = 0; op < 64; op++) begin
         drive(1'b1, 32, mk(op, $urandom_range(31), $urandom_range(31),
                            $urandom_range(65535)));
         step();
         if (enable_o === 1'b1) cnt++;
         n_checks++;
         if (enable_o !== ref_ok(op)) begin
            n_fail++;
            $display("FAIL sweep_op%0d: got %b want %b", op, enable_o,
                     ref_ok(op));
         end
      end
      n_checks++;
      if (cnt != want) begin
         n_fail++; $display("FAIL sweep_count: got %0d want %0d", cnt, want);
      end
      drive(1'b0, 32, mk(14, 1, 1, 1));
      step();
      n_checks++;
      if (enable_o !== 1'b0) begin
         n_fail++; $display("FAIL enable_drop: got %b want 0", enable_o);
      end
   endtask

   task automatic test_stall();
      logic [63:0]  h;
      logic [164:0] p;
      drive(1'b1, 32, 32'h3C601234);
      step();
      h = ref_hdr(32'h3C601234);
      p = dut_pt();
      stall_i = 1'b1;
      drive(1'b1, 32, 32'h84A40008);
      step();
      step();
      n_checks++;
      if ({enable_o, dut_hdr(), dut_pt()} !== {1'b1, h, p}) begin
         n_fail++;
         $display("FAIL stall_hold: got %h want %h", dut_hdr(), h);
      end
      stall_i = 1'b0;
      step();
      n_checks++;
      if (dut_hdr() !== ref_hdr(32'h84A40008) || enable_o !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_release: got %h want %h", dut_hdr(),
                  ref_hdr(32'h84A40008));
      end
   endtask

   task automatic test_async_reset();
      drive(1'b1, 32, mk(13, 7, 9, 16'h8001));
      step();
      drive(1'b0, 32, 32'h0);
      #3;
      reset_i = 1'b1;
      #1;
      n_checks++;
      if ({enable_o, dut_hdr(), dut_pt()} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got %h want 0",
                  {enable_o, dut_hdr(), dut_pt()});
      end
      step();
      reset_i = 1'b0;
      step();
      n_checks++;
      if (enable_o !== 1'b0) begin
         n_fail++; $display("FAIL reset_drop: got %b want 0", enable_o);
      end
   endtask

   task automatic test_random();
      bit           exp_en;
      logic [63:0]  exp_h;
      logic [164:0] exp_p;
      logic [31:0]  ins;
      int           fmt;
      bit           en;
      exp_en = 1'b0;
      exp_h  = '0;
      exp_p  = '0;
      for (int i = 0; i < 400; i++) begin
         ins = mk($urandom_range(63), $urandom_range(31),
                  ($urandom_range(3) == 0) ? 0 : $urandom_range(31),
                  $urandom_range(65535));
         fmt = ($urandom_range(7) == 0) ? $urandom_range(64) : 32;
         en  = ($urandom_range(9) < 7);
         stall_i = ($urandom_range(4) == 0);
         drive(en, fmt, ins);
         if (!stall_i) begin
            exp_en = en && fmt == 32 && ref_ok(int'(ins[31:26]));
            if (en) begin
               exp_h = ref_hdr(ins);
               exp_p = {instructionAddress_i, is64Bit_i, instructionPid_i,
                        instructionTid_i, instructionMajId_i};
            end
         end
         step();
         n_checks++;
         if (enable_o !== exp_en) begin
            n_fail++;
            $display("FAIL rand_en[%0d]: got %b want %b", i, enable_o, exp_en);
         end
         if (exp_en) begin
            n_checks++;
            if (dut_hdr() !== exp_h || dut_pt() !== exp_p) begin
               n_fail++;
               $display("FAIL rand_hdr[%0d]: got %h want %h", i, dut_hdr(),
                        exp_h);
            end
         end
      end
      stall_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_addis();
      test_loads();
      test_andi_and_format();
      test_sweep();
      test_stall();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
